// File: rtl/mmc3_irq_ctr_pkg.sv
// ---------------------------------------------------------------------------
// mmc3_irq_ctr_pkg
// Shared constants for the MMC3/MMC6 scanline IRQ counter and the A12
// edge filter:
//   - register decode values for {cpu_a14, cpu_a13, cpu_a0} on $8000-$FFFF
//     writes ($C000 latch, $C001 reload, $E000 disable/ack, $E001 enable)
//   - savestate register indices exposed on the sst_* bus
//   - width of the M2-low filter counter
// ---------------------------------------------------------------------------
package mmc3_irq_ctr_pkg;

  localparam logic [2:0] REG_C000 = 3'b100;
  localparam logic [2:0] REG_C001 = 3'b101;
  localparam logic [2:0] REG_E000 = 3'b110;
  localparam logic [2:0] REG_E001 = 3'b111;

  localparam logic [7:0] SST_IRQ_CTR = 8'd34;
  localparam logic [7:0] SST_IRQ_LAT = 8'd35;
  localparam logic [7:0] SST_IRQ_FLG = 8'd36;

  // The filter counter saturates at FILT_M2, which must fit in this width.
  localparam int LOWCNT_W = 2;

endpackage

// File: rtl/mmc3_irq_ctr_a12_filter.sv
// ---------------------------------------------------------------------------
// mmc3_irq_ctr_a12_filter
// Brings CPU M2 and PPU A12 into the clk domain and qualifies A12 rising
// edges: an edge only counts if A12 has been low for at least FILT_M2
// M2 falling edges, which rejects the fast A12 toggling of PPU fetches.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   cpu_m2   in   CPU M2 (asynchronous)
//   ppu_a12  in   PPU A12 (asynchronous)
//   freeze   in   suppresses all outputs and holds the low counter
//   m2_fall  out  one-clk pulse on synchronised M2 falling edge
//   a12_evt  out  one-clk pulse on a qualified A12 rising edge
// ---------------------------------------------------------------------------
module mmc3_irq_ctr_a12_filter
  import mmc3_irq_ctr_pkg::*;
#(
  parameter int FILT_M2 = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_m2,
  input  logic ppu_a12,
  input  logic freeze,
  output logic m2_fall,
  output logic a12_evt
);

  localparam logic [LOWCNT_W-1:0] FILT_MAX = LOWCNT_W'(FILT_M2);

  logic m2_p0, m2_p1, m2_p2;
  logic a12_p0, a12_p1, a12_p2;
  logic [LOWCNT_W-1:0] lowcnt;
  logic m2_fall_raw;
  logic a12_rise_raw;

  // Stage p0/p1: two-flop synchronisers. Stage p2: edge history.
  // The history keeps tracking while frozen, so no stale edge fires on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_p0  <= 1'b0;
      m2_p1  <= 1'b0;
      m2_p2  <= 1'b0;
      a12_p0 <= 1'b0;
      a12_p1 <= 1'b0;
      a12_p2 <= 1'b0;
    end else begin
      m2_p0  <= cpu_m2;
      m2_p1  <= m2_p0;
      m2_p2  <= m2_p1;
      a12_p0 <= ppu_a12;
      a12_p1 <= a12_p0;
      a12_p2 <= a12_p1;
    end
  end

  assign m2_fall_raw  = m2_p2 & ~m2_p1;
  assign a12_rise_raw = a12_p1 & ~a12_p2;

  // A12-high clears the count; the rising-edge cycle still sees the old
  // count because the clear lands on the same edge the event is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lowcnt <= '0;
    end else if (!freeze) begin
      if (a12_p1) begin
        lowcnt <= '0;
      end else if (m2_fall_raw && (lowcnt != FILT_MAX)) begin
        lowcnt <= lowcnt + 1'b1;
      end
    end
  end

  assign m2_fall = m2_fall_raw & ~freeze;
  assign a12_evt = a12_rise_raw & (lowcnt == FILT_MAX) & ~freeze;

endmodule

// File: rtl/mmc3_irq_ctr.sv
// ---------------------------------------------------------------------------
// mmc3_irq_ctr
// MMC3/MMC6 scanline IRQ counter. Filters PPU A12 rises, runs the
// reloadable 8-bit down-counter, decodes the $C000/$C001/$E000/$E001
// writes and drives the active-low IRQ pin. State is visible and writable
// through the savestate bus.
//
// Parameters:
//   FILT_M2  M2 falling edges A12 must stay low before a rise counts
//   IRQ_REV  0 = Sharp (IRQ whenever counter is 0 after a clock)
//            1 = NEC (IRQ on decrement to 0, or reload of a zero latch
//                with the reload flag set)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_m2, cpu_rw, cpu_ce_n   CPU bus timing/control
//   cpu_a14, cpu_a13, cpu_a0   register select
//   cpu_data[7:0]              CPU write data
//   ppu_a12                    PPU address line A12
//   sst_act, sst_we            savestate active / write strobe
//   sst_addr[7:0]              savestate register index
//   sst_dato[7:0]              savestate write data
//   sst_di[7:0]                savestate read data (combinational)
//   irq_n                      registered IRQ output, active low
// ---------------------------------------------------------------------------
module mmc3_irq_ctr
  import mmc3_irq_ctr_pkg::*;
#(
  parameter int FILT_M2 = 3,
  parameter int IRQ_REV = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_m2,
  input  logic       cpu_rw,
  input  logic       cpu_ce_n,
  input  logic       cpu_a14,
  input  logic       cpu_a13,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_data,
  input  logic       ppu_a12,
  input  logic       sst_act,
  input  logic       sst_we,
  input  logic [7:0] sst_addr,
  input  logic [7:0] sst_dato,
  output logic [7:0] sst_di,
  output logic       irq_n
);

  logic m2_fall;
  logic a12_evt;

  mmc3_irq_ctr_a12_filter #(
    .FILT_M2 (FILT_M2)
  ) u_a12_filter (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_m2  (cpu_m2),
    .ppu_a12 (ppu_a12),
    .freeze  (sst_act),
    .m2_fall (m2_fall),
    .a12_evt (a12_evt)
  );

  logic [7:0] latch_q, counter_q;
  logic       reload_q, irq_en_q, pend_q, irq_n_q;
  logic [7:0] latch_nx, counter_nx;
  logic       reload_nx, irq_en_nx, pend_nx;

  logic       cpu_wr;
  logic [2:0] reg_sel;
  logic       sst_wr;
  logic       reload_path;
  logic       irq_hit;

  assign reg_sel = {cpu_a14, cpu_a13, cpu_a0};
  assign cpu_wr  = m2_fall & ~cpu_rw & ~cpu_ce_n & ~sst_act;
  assign sst_wr  = sst_act & sst_we;

  // Priority is by statement order: the A12 event is evaluated first from
  // the old register values, then CPU writes override it ($C001 wins over
  // the counter update, $E000 wins over a new pend), then savestate writes.
  always_comb begin
    latch_nx    = latch_q;
    counter_nx  = counter_q;
    reload_nx   = reload_q;
    irq_en_nx   = irq_en_q;
    pend_nx     = pend_q;
    irq_hit     = 1'b0;
    reload_path = (counter_q == 8'd0) || reload_q;

    if (a12_evt) begin
      if (reload_path) begin
        counter_nx = latch_q;
        reload_nx  = 1'b0;
      end else begin
        counter_nx = counter_q - 8'd1;
      end

      if (IRQ_REV == 0) begin
        irq_hit = (counter_nx == 8'd0);
      end else begin
        // NEC parts only fire on a true 1->0 step or on a forced reload
        // of a zero latch; a natural 0->0 reload stays silent.
        irq_hit = reload_path ? (reload_q && (latch_q == 8'd0))
                              : (counter_q == 8'd1);
      end

      if (irq_hit && irq_en_q) begin
        pend_nx = 1'b1;
      end
    end

    if (cpu_wr) begin
      case (reg_sel)
        REG_C000: latch_nx = cpu_data;
        REG_C001: begin
          counter_nx = 8'd0;
          reload_nx  = 1'b1;
        end
        REG_E000: begin
          irq_en_nx = 1'b0;
          pend_nx   = 1'b0;
        end
        REG_E001: irq_en_nx = 1'b1;
        default: ;
      endcase
    end

    if (sst_wr) begin
      case (sst_addr)
        SST_IRQ_CTR: counter_nx = sst_dato;
        SST_IRQ_LAT: latch_nx   = sst_dato;
        SST_IRQ_FLG: begin
          reload_nx = sst_dato[2];
          irq_en_nx = sst_dato[1];
          pend_nx   = sst_dato[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= 8'd0;
      counter_q <= 8'd0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      latch_q   <= latch_nx;
      counter_q <= counter_nx;
      reload_q  <= reload_nx;
      irq_en_q  <= irq_en_nx;
      pend_q    <= pend_nx;
    end
  end

  // Output register: one clk after pend changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_n_q <= 1'b1;
    end else begin
      irq_n_q <= ~pend_q;
    end
  end

  assign irq_n = irq_n_q;

  // Readback is forced to 8'hFF while reset is held so the savestate bus
  // never shows half-cleared state.
  always_comb begin
    sst_di = 8'hFF;
    if (rst_n) begin
      case (sst_addr)
        SST_IRQ_CTR: sst_di = counter_q;
        SST_IRQ_LAT: sst_di = latch_q;
        SST_IRQ_FLG: sst_di = {5'b0, reload_q, irq_en_q, pend_q};
        default:     sst_di = 8'hFF;
      endcase
    end
  end

endmodule

// File: tb/tb_mmc3_irq_ctr.sv
module tb_mmc3_irq_ctr;
  import mmc3_irq_ctr_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_m2, cpu_rw, cpu_ce_n, cpu_a14, cpu_a13, cpu_a0;
  logic [7:0] cpu_data;
  logic       ppu_a12;
  logic       sst_act, sst_we;
  logic [7:0] sst_addr, sst_dato;
  logic [7:0] sst_di0, sst_di1;
  logic       irq_n0, irq_n1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmc3_irq_ctr #(.FILT_M2(3), .IRQ_REV(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_ce_n(cpu_ce_n), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13),
    .cpu_a0(cpu_a0), .cpu_data(cpu_data), .ppu_a12(ppu_a12),
    .sst_act(sst_act), .sst_we(sst_we), .sst_addr(sst_addr),
    .sst_dato(sst_dato), .sst_di(sst_di0), .irq_n(irq_n0)
  );

  mmc3_irq_ctr #(.FILT_M2(3), .IRQ_REV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2), .cpu_rw(cpu_rw),
    .cpu_ce_n(cpu_ce_n), .cpu_a14(cpu_a14), .cpu_a13(cpu_a13),
    .cpu_a0(cpu_a0), .cpu_data(cpu_data), .ppu_a12(ppu_a12),
    .sst_act(sst_act), .sst_we(sst_we), .sst_addr(sst_addr),
    .sst_dato(sst_dato), .sst_di(sst_di1), .irq_n(irq_n1)
  );

  typedef enum logic {OP_WR, OP_EVT} op_t;
  typedef struct {
    op_t        op;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp_ctr;
    logic       exp_irq_n;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [7:0] idx, input logic [7:0] exp);
    sst_addr = idx;
    #1;
    chk(nm, sst_di0, exp);
  endtask

  task automatic m2_cycle(input logic wr, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_rw   = ~wr;
    cpu_ce_n = ~wr;
    {cpu_a14, cpu_a13, cpu_a0} = a;
    cpu_data = d;
    cpu_m2   = 1'b1;
    repeat (6) @(negedge clk);
    cpu_m2 = 1'b0;
    repeat (6) @(negedge clk);
    cpu_rw   = 1'b1;
    cpu_ce_n = 1'b1;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
    m2_cycle(1'b1, a, d);
  endtask

  task automatic m2_idle();
    m2_cycle(1'b0, 3'b000, 8'h00);
  endtask

  // Three M2 falls with A12 low, then a clean A12 pulse.
  task automatic a12_event();
    repeat (3) m2_idle();
    @(negedge clk);
    ppu_a12 = 1'b1;
    repeat (6) @(negedge clk);
    ppu_a12 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // CPU write whose M2 fall lands on the same clk as a qualified A12 rise.
  task automatic wr_with_evt(input logic [2:0] a, input logic [7:0] d);
    repeat (3) m2_idle();
    @(negedge clk);
    cpu_rw   = 1'b0;
    cpu_ce_n = 1'b0;
    {cpu_a14, cpu_a13, cpu_a0} = a;
    cpu_data = d;
    cpu_m2   = 1'b1;
    repeat (6) @(negedge clk);
    cpu_m2  = 1'b0;
    ppu_a12 = 1'b1;
    repeat (6) @(negedge clk);
    cpu_rw   = 1'b1;
    cpu_ce_n = 1'b1;
    ppu_a12  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic sst_write(input logic [7:0] idx, input logic [7:0] d);
    @(negedge clk);
    sst_addr = idx;
    sst_dato = d;
    sst_we   = 1'b1;
    @(negedge clk);
    sst_we = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{OP_WR,  REG_C000, 8'd2, 8'd0, 1'b1};
    tbl[1]  = '{OP_WR,  REG_E001, 8'd0, 8'd0, 1'b1};
    tbl[2]  = '{OP_EVT, 3'b000,   8'd0, 8'd2, 1'b1};
    tbl[3]  = '{OP_EVT, 3'b000,   8'd0, 8'd1, 1'b1};
    tbl[4]  = '{OP_EVT, 3'b000,   8'd0, 8'd0, 1'b0};
    tbl[5]  = '{OP_EVT, 3'b000,   8'd0, 8'd2, 1'b0};
    tbl[6]  = '{OP_WR,  REG_E000, 8'd0, 8'd2, 1'b1};
    tbl[7]  = '{OP_WR,  REG_E001, 8'd0, 8'd2, 1'b1};
    tbl[8]  = '{OP_EVT, 3'b000,   8'd0, 8'd1, 1'b1};
    tbl[9]  = '{OP_WR,  REG_C001, 8'd0, 8'd0, 1'b1};
    tbl[10] = '{OP_WR,  REG_C000, 8'd5, 8'd0, 1'b1};
    tbl[11] = '{OP_EVT, 3'b000,   8'd0, 8'd5, 1'b1};
    tbl[12] = '{OP_EVT, 3'b000,   8'd0, 8'd4, 1'b1};

    rst_n = 1'b0; cpu_m2 = 1'b0; cpu_rw = 1'b1; cpu_ce_n = 1'b1;
    cpu_a14 = 1'b0; cpu_a13 = 1'b0; cpu_a0 = 1'b0; cpu_data = 8'h00;
    ppu_a12 = 1'b0; sst_act = 1'b0; sst_we = 1'b0;
    sst_addr = SST_IRQ_CTR; sst_dato = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_irq_n", {7'b0, irq_n0}, 8'h01);
    chk("rst_sst_di", sst_di0, 8'hFF);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reg("rst_ctr", SST_IRQ_CTR, 8'h00);
    chk_reg("rst_lat", SST_IRQ_LAT, 8'h00);
    chk_reg("rst_flg", SST_IRQ_FLG, 8'h00);

    // Main sequence
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].op == OP_WR) cpu_wr(tbl[i].a, tbl[i].d);
      else                    a12_event();
      chk_reg($sformatf("vec%0d_ctr", i), SST_IRQ_CTR, tbl[i].exp_ctr);
      chk($sformatf("vec%0d_irq_n", i), {7'b0, irq_n0}, {7'b0, tbl[i].exp_irq_n});
    end

    // Exact A12-to-irq_n latency: counter 1 -> 0 with irq enabled
    cpu_wr(REG_C000, 8'd1);
    cpu_wr(REG_C001, 8'd0);
    a12_event();
    chk_reg("lat_pre_ctr", SST_IRQ_CTR, 8'd1);
    repeat (3) m2_idle();
    @(negedge clk);
    ppu_a12 = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_clk3_irq_n", {7'b0, irq_n0}, 8'h01);
    @(negedge clk);
    chk("lat_clk4_irq_n", {7'b0, irq_n0}, 8'h00);
    repeat (3) @(negedge clk);
    ppu_a12 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reg("lat_ctr", SST_IRQ_CTR, 8'd0);
    cpu_wr(REG_E000, 8'd0);
    chk("ack_irq_n", {7'b0, irq_n0}, 8'h01);

    // Filter: A12 low for only one M2 fall is rejected
    a12_event();
    chk_reg("filt_base_ctr", SST_IRQ_CTR, 8'd1);
    m2_idle();
    @(negedge clk);
    ppu_a12 = 1'b1;
    repeat (6) @(negedge clk);
    ppu_a12 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reg("filt_reject_ctr", SST_IRQ_CTR, 8'd1);
    a12_event();
    chk_reg("filt_accept_ctr", SST_IRQ_CTR, 8'd0);

    // $C001 coinciding with an event: the write wins
    cpu_wr(REG_C000, 8'd7);
    a12_event();
    chk_reg("c001_pre_ctr", SST_IRQ_CTR, 8'd7);
    wr_with_evt(REG_C001, 8'd0);
    chk_reg("c001_coin_ctr", SST_IRQ_CTR, 8'd0);
    chk_reg("c001_coin_flg", SST_IRQ_FLG, 8'h04);
    a12_event();
    chk_reg("c001_next_ctr", SST_IRQ_CTR, 8'd7);

    // $E000 coinciding with a decrement to 0: pend stays clear
    cpu_wr(REG_E001, 8'd0);
    cpu_wr(REG_C000, 8'd1);
    cpu_wr(REG_C001, 8'd0);
    a12_event();
    chk_reg("e000_pre_ctr", SST_IRQ_CTR, 8'd1);
    wr_with_evt(REG_E000, 8'd0);
    chk_reg("e000_coin_ctr", SST_IRQ_CTR, 8'd0);
    chk_reg("e000_coin_flg", SST_IRQ_FLG, 8'h00);
    chk("e000_coin_irq_n", {7'b0, irq_n0}, 8'h01);

    // Sharp vs NEC with latch 0
    cpu_wr(REG_C000, 8'd0);
    cpu_wr(REG_E001, 8'd0);
    cpu_wr(REG_C001, 8'd0);
    a12_event();
    chk("rev0_first_irq_n", {7'b0, irq_n0}, 8'h00);
    chk("rev1_first_irq_n", {7'b0, irq_n1}, 8'h00);
    cpu_wr(REG_E000, 8'd0);
    cpu_wr(REG_E001, 8'd0);
    chk("rev0_ack_irq_n", {7'b0, irq_n0}, 8'h01);
    chk("rev1_ack_irq_n", {7'b0, irq_n1}, 8'h01);
    a12_event();
    chk("rev0_second_irq_n", {7'b0, irq_n0}, 8'h00);
    chk("rev1_second_irq_n", {7'b0, irq_n1}, 8'h01);

    // Savestate access
    cpu_wr(REG_E000, 8'd0);
    chk("sst_pre_irq_n", {7'b0, irq_n0}, 8'h01);
    @(negedge clk);
    sst_act = 1'b1;
    sst_write(SST_IRQ_CTR, 8'd5);
    sst_write(SST_IRQ_FLG, 8'h03);
    repeat (2) @(negedge clk);
    chk("sst_irq_n", {7'b0, irq_n0}, 8'h00);
    chk_reg("sst_rd34", SST_IRQ_CTR, 8'd5);
    chk("sst_rd34_dut1", sst_di1, 8'd5);
    chk_reg("sst_rd36", SST_IRQ_FLG, 8'h03);
    chk_reg("sst_rd99", 8'd99, 8'hFF);
    a12_event();
    chk_reg("sst_frozen_a12_ctr", SST_IRQ_CTR, 8'd5);
    cpu_wr(REG_C001, 8'd0);
    cpu_wr(REG_E000, 8'd0);
    chk_reg("sst_frozen_cpu_ctr", SST_IRQ_CTR, 8'd5);
    chk("sst_frozen_irq_n", {7'b0, irq_n0}, 8'h00);
    @(negedge clk);
    sst_act = 1'b0;
    a12_event();
    chk_reg("sst_exit_ctr", SST_IRQ_CTR, 8'd4);

    // Asynchronous reset mid-operation
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_irq_n", {7'b0, irq_n0}, 8'h01);
    chk("async_rst_sst_di", sst_di0, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reg("post_rst_ctr", SST_IRQ_CTR, 8'h00);
    chk_reg("post_rst_flg", SST_IRQ_FLG, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
